pio_edge_capture_in: RTL

- Avalon-MM slave input port, the read-side counterpart of the SoC's write-only output PIOs.
- Samples WIDTH external signals (board keys, game status lines) into the clk domain.
- Detects edges into sticky edge-capture bits and raises a maskable level interrupt to the Nios II.
- CPU reads live data, reads/clears captured edges, and programs the interrupt mask.

---
 rtl/pio_edge_capture_in.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/pio_edge_capture_in.sv
// Avalon-MM input PIO: synchronized inputs, sticky edge capture, masked irq.
// Optional per-bit input debounce is built when PIO_DEBOUNCE_EN is defined.
module pio_edge_capture_in #(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_edge_cap;
  logic [WIDTH-1:0] r_irq_mask;
  logic [1:0]       r_arm_cnt;
  logic             r_irq;

  logic [WIDTH-1:0] w_d;
  logic [WIDTH-1:0] w_d_nxt;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_ev;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_wdata;
  logic             w_armed;
  logic             w_wr;
  logic             w_sel_data;
  logic             w_sel_rsvd;
  logic             w_sel_mask;
  logic             w_sel_cap;
  logic             w_unused;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PIO_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1
                    : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0]    r_cnt [WIDTH];
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] w_stable_nxt;

  always_comb begin
    w_stable_nxt = r_stable;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_sync2[i] != r_stable[i] && r_cnt[i] == CMAX)
        w_stable_nxt[i] = r_sync2[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable <= '0;
      for (int i = 0; i < WIDTH; i++)
        r_cnt[i] <= '0;
    end else begin
      r_stable <= w_stable_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] == r_stable[i])
          r_cnt[i] <= '0;
        else if (r_cnt[i] == CMAX)
          r_cnt[i] <= '0;
        else
          r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  assign w_d     = r_stable;
  assign w_d_nxt = w_stable_nxt;
`else
  assign w_d     = r_sync2;
  assign w_d_nxt = r_sync1;
`endif

  assign w_armed = (r_arm_cnt == 2'd2);
  assign w_rise  = w_d & ~r_prev;
  assign w_fall  = ~w_d & r_prev;

  always_comb begin
    w_ev = '0;
    if (w_armed) begin
      case (EDGE_TYPE)
        0:       w_ev = w_rise;
        1:       w_ev = w_fall;
        default: w_ev = w_rise | w_fall;
      endcase
    end
  end

  assign w_sel_data = (address == 2'd0);
  assign w_sel_rsvd = (address == 2'd1);
  assign w_sel_mask = (address == 2'd2);
  assign w_sel_cap  = (address == 2'd3);
  assign w_wr       = chipselect & ~write_n;
  assign w_wdata    = writedata[WIDTH-1:0];
  assign w_clr      = (w_wr && w_sel_cap) ? w_wdata : '0;
  assign w_unused   = ^writedata;

  // Until armed, prev tracks the value d takes next, so the first armed
  // compare sees a settled reference and a line high at reset is no edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_arm_cnt <= '0;
      r_prev    <= '0;
    end else begin
      if (!w_armed)
        r_arm_cnt <= r_arm_cnt + 2'd1;
      r_prev <= w_armed ? w_d : w_d_nxt;
    end
  end

  // Set has priority over a same-cycle write-1-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge_cap <= '0;
      r_irq_mask <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_edge_cap <= (r_edge_cap & ~w_clr) | w_ev;
      if (w_wr && w_sel_mask)
        r_irq_mask <= w_wdata;
      r_irq <= |(r_edge_cap & r_irq_mask);
    end
  end

  assign irq = r_irq;

  always_comb begin
    readdata = '0;
    unique case (1'b1)
      w_sel_data: readdata[WIDTH-1:0] = w_d;
      w_sel_rsvd: readdata = '0;
      w_sel_mask: readdata[WIDTH-1:0] = r_irq_mask;
      w_sel_cap:  readdata[WIDTH-1:0] = r_edge_cap;
      default:    readdata = '0;
    endcase
  end

endmodule
